ps2_keyboard_rx_fifo: RTL and testbench

//  System-clocked PS/2 keyboard receiver. Oversamples PS2KeyboardClk/Data on clk, frames
//  11-bit PS/2 packets (start, 8 data LSB-first, odd parity, stop), decodes E0/F0 prefixes

---
 rtl/ps2_keyboard_rx_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_keyboard_rx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver: synchronise, frame, decode E0/F0 prefixes, queue tagged words.
// Word reaches the FIFO SYNC_STAGES+3 clk after the stop-bit edge; a push into a full FIFO drops the word unless popped the same cycle.
module ps2_keyboard_rx_fifo #(
    parameter int FIFO_DEPTH   = 8,
    parameter int TIMEOUT_CYC  = 50000,
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_BREAK = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          PS2KeyboardClk,
    input  logic                          PS2KeyboardData,
    input  logic                          rd_en,
    output logic [9:0]                    IO_to_memcon_data,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [7:0]                    led
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat_s;
    logic                   ps2_fall;

    state_t      state, state_nxt;
    logic [7:0]  sh, sh_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic        par_ok, par_ok_nxt;
    logic        err_nxt;
    logic        bvld_nxt;
    logic        timeout;
    logic [TW-1:0] tcnt;

    logic        byte_vld;
    logic [7:0]  byte_dat;
    logic        ext;
    logic        brk;
    logic        push_vld;
    logic [9:0]  push_dat;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop;
    logic          push_ok;

    // Both lines idle high, so the synchronisers reset to 1 to avoid a fake edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2KeyboardClk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2KeyboardData};
            clk_prev <= clk_s;
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign dat_s    = dat_sync[SYNC_STAGES-1];
    assign ps2_fall = clk_prev & ~clk_s;

    always_comb begin
        state_nxt   = state;
        sh_nxt      = sh;
        bit_cnt_nxt = bit_cnt;
        par_ok_nxt  = par_ok;
        err_nxt     = 1'b0;
        bvld_nxt    = 1'b0;
        timeout     = 1'b0;
        if (ps2_fall) begin
            case (state)
                IDLE: begin
                    if (!dat_s) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 3'd0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                DATA: begin
                    sh_nxt[bit_cnt] = dat_s;
                    bit_cnt_nxt     = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    par_ok_nxt = ^{sh, dat_s};
                    state_nxt  = STOP;
                end
                STOP: begin
                    if (dat_s && par_ok) begin
                        bvld_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
            timeout   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            sh        <= '0;
            bit_cnt   <= '0;
            par_ok    <= 1'b0;
            frame_err <= 1'b0;
            byte_vld  <= 1'b0;
            byte_dat  <= '0;
        end else begin
            state     <= state_nxt;
            sh        <= sh_nxt;
            bit_cnt   <= bit_cnt_nxt;
            par_ok    <= par_ok_nxt;
            frame_err <= err_nxt;
            byte_vld  <= bvld_nxt;
            if (bvld_nxt) begin
                byte_dat <= sh;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if (ps2_fall || state == IDLE || timeout) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // Prefix bytes only arm the flags; the next ordinary byte carries and clears them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ext      <= 1'b0;
            brk      <= 1'b0;
            push_vld <= 1'b0;
            push_dat <= '0;
        end else begin
            push_vld <= 1'b0;
            if (timeout) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_vld) begin
                if (byte_dat == 8'hE0) begin
                    ext <= 1'b1;
                end else if (byte_dat == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    push_vld <= (FILTER_BREAK == 0) || !brk;
                    push_dat <= {ext, brk, byte_dat};
                    ext      <= 1'b0;
                    brk      <= 1'b0;
                end
            end
        end
    end

    assign pop     = rd_en && (count != '0);
    assign push_ok = push_vld && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            led      <= '0;
        end else begin
            overflow <= push_vld && !push_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (!push_dat[8]) begin
                    led <= push_dat[7:0];
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    assign fifo_count        = count;
    assign fifo_empty        = (count == '0);
    assign fifo_full         = (count == CW'(FIFO_DEPTH));
    assign IO_to_memcon_data = fifo_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
// Two receivers (break words kept / filtered) share the PS/2 pins and rd_en; a queue model predicts both.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx_fifo;
    localparam int HP    = 20;
    localparam int TMO   = 300;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, ps2c, ps2d, rd_en;
    logic [1:0][9:0] dat;
    logic [1:0][3:0] cnt;
    logic [1:0][7:0] led;
    logic [1:0]      emp, ful, ferr, ovf;

    ps2_keyboard_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .SYNC_STAGES(2), .FILTER_BREAK(0)) u_keep (
        .clk(clk), .reset_n(reset_n), .PS2KeyboardClk(ps2c), .PS2KeyboardData(ps2d), .rd_en(rd_en),
        .IO_to_memcon_data(dat[0]), .fifo_empty(emp[0]), .fifo_full(ful[0]), .fifo_count(cnt[0]),
        .frame_err(ferr[0]), .overflow(ovf[0]), .led(led[0]));

    ps2_keyboard_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .SYNC_STAGES(2), .FILTER_BREAK(1)) u_filt (
        .clk(clk), .reset_n(reset_n), .PS2KeyboardClk(ps2c), .PS2KeyboardData(ps2d), .rd_en(rd_en),
        .IO_to_memcon_data(dat[1]), .fifo_empty(emp[1]), .fifo_full(ful[1]), .fifo_count(cnt[1]),
        .frame_err(ferr[1]), .overflow(ovf[1]), .led(led[1]));

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [7:0] m_led [2];
    int         m_ovf [2];
    int         m_err;
    bit         m_ext, m_brk;
    int         seen_err [2];
    int         seen_ovf [2];
    int         checks = 0;
    int         failures = 0;
    bit         settled = 0;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                seen_err[k] <= 0;
                seen_ovf[k] <= 0;
            end else begin
                seen_err[k] <= seen_err[k] + (ferr[k] ? 1 : 0);
                seen_ovf[k] <= seen_ovf[k] + (ovf[k] ? 1 : 0);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int msize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int mhead(input int k);
        if (msize(k) == 0) return 0;
        return (k == 0) ? int'(q0[0]) : int'(q1[0]);
    endfunction

    task automatic m_push(input int k, input logic [9:0] w);
        if (msize(k) < DEPTH) begin
            if (k == 0) q0.push_back(w); else q1.push_back(w);
            if (!w[8]) m_led[k] = w[7:0];
        end else begin
            m_ovf[k]++;
        end
    endtask

    task automatic m_pop();
        logic [9:0] d;
        if (q0.size() > 0) d = q0.pop_front();
        if (q1.size() > 0) d = q1.pop_front();
    endtask

    task automatic m_byte(input logic [7:0] b);
        logic [9:0] w;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            w = {m_ext, m_brk, b};
            m_push(0, w);
            if (!m_brk) m_push(1, w);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic m_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_led[k] = 8'h00;
            m_ovf[k] = 0;
        end
        m_err = 0;
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("cmp_count%0d", k), cnt[k], msize(k));
            check($sformatf("cmp_head%0d", k), dat[k], mhead(k));
            check($sformatf("cmp_empty%0d", k), emp[k], msize(k) == 0);
            check($sformatf("cmp_full%0d", k), ful[k], msize(k) == DEPTH);
            check($sformatf("cmp_led%0d", k), led[k], m_led[k]);
            check($sformatf("cmp_errs%0d", k), seen_err[k], m_err);
            check($sformatf("cmp_ovfs%0d", k), seen_ovf[k], m_ovf[k]);
        end
    endtask

    // Drive n PS/2 bits; optionally raise rd_en for the cycle the last bit's word is pushed.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit rd_at_push);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2d = bits[i];
            repeat (5) @(negedge clk);
            ps2c = 1'b0;
            if (rd_at_push && i == n - 1) begin
                repeat (4) @(posedge clk);
                @(negedge clk) rd_en = 1'b1;
                @(negedge clk) rd_en = 1'b0;
                repeat (HP - 5) @(negedge clk);
            end else begin
                repeat (HP) @(negedge clk);
            end
            ps2c = 1'b1;
            repeat (HP - 6) @(negedge clk);
        end
        @(negedge clk) ps2d = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit rd_at_push);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        settled = 0;
        send_bits(bits, 11, rd_at_push);
        repeat (8) @(negedge clk);
        if (bad_par || bad_stop) begin
            m_err++;
        end else begin
            if (rd_at_push) m_pop();
            m_byte(b);
        end
        settled = 1;
    endtask

    task automatic bad_start();
        logic [10:0] ones;
        ones = '1;
        settled = 0;
        send_bits(ones, 1, 1'b0);
        repeat (8) @(negedge clk);
        m_err++;
        settled = 1;
    endtask

    task automatic partial(input logic [7:0] b, input int nd);
        logic [10:0] bits;
        bits = {2'b11, b, 1'b0};
        settled = 0;
        send_bits(bits, 1 + nd, 1'b0);
    endtask

    task automatic do_read();
        settled = 0;
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
        m_pop();
        settled = 1;
    endtask

    task automatic reset_values(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_count"}, cnt[k], 0);
            check({tag, "_empty"}, emp[k], 1);
            check({tag, "_full"}, ful[k], 0);
            check({tag, "_data"}, dat[k], 0);
            check({tag, "_led"}, led[k], 0);
            check({tag, "_ferr"}, ferr[k], 0);
            check({tag, "_ovf"}, ovf[k], 0);
        end
    endtask

    initial begin
        #950us;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset_n = 1'b0;
        ps2c = 1'b1;
        ps2d = 1'b1;
        rd_en = 1'b0;
        m_reset();
        fork
            forever begin
                @(posedge clk);
                #2;
                if (settled) compare_all();
            end
        join_none
        repeat (3) @(negedge clk);
        reset_values("rst0");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        settled = 1;

        // single make code
        frame(8'h1C, 0, 0, 0);
        check("t1_word", dat[0], 10'h01C);
        check("t1_count", cnt[0], 1);
        check("t1_led", led[0], 8'h1C);
        do_read();
        check("t1_empty", emp[0], 1);

        // extended break sequence
        frame(8'hE0, 0, 0, 0);
        frame(8'hF0, 0, 0, 0);
        frame(8'h74, 0, 0, 0);
        check("t2_keep_word", dat[0], 10'h374);
        check("t2_filt_count", cnt[1], 0);
        check("t2_led_kept", led[0], 8'h1C);
        do_read();
        frame(8'h1C, 0, 0, 0);
        check("t2_flags_clr_keep", dat[0], 10'h01C);
        check("t2_flags_clr_filt", dat[1], 10'h01C);
        do_read();

        // framing errors
        frame(8'h1C, 1, 0, 0);
        check("t3_par_err", seen_err[0], 1);
        check("t3_par_nopush", cnt[0], 0);
        frame(8'h1C, 0, 1, 0);
        check("t3_stop_err", seen_err[0], 2);
        bad_start();
        check("t3_start_err", seen_err[1], 3);

        // timeout mid-frame with a pending E0 prefix
        frame(8'hE0, 0, 0, 0);
        partial(8'h5A, 4);
        repeat (TMO + 20) @(negedge clk);
        m_err++;
        m_ext = 0;
        m_brk = 0;
        settled = 1;
        check("t4_tmo_err", seen_err[0], 4);
        frame(8'h29, 0, 0, 0);
        check("t4_word", dat[0], 10'h029);
        do_read();

        // overflow and simultaneous push/pop when full
        for (int i = 1; i <= DEPTH + 1; i++) frame(8'(i), 0, 0, 0);
        check("t5_full", ful[0], 1);
        check("t5_ovf", seen_ovf[0], 1);
        check("t5_led", led[0], 8'h08);
        for (int i = 1; i <= DEPTH; i++) begin
            check($sformatf("t5_read%0d", i), dat[0], i);
            do_read();
        end
        check("t5_drained", emp[0], 1);
        for (int i = 0; i < DEPTH; i++) frame(8'h11 + 8'(i), 0, 0, 0);
        frame(8'h19, 0, 0, 1);
        check("t5_rw_count", cnt[0], 8);
        check("t5_rw_noovf", seen_ovf[0], 1);
        check("t5_rw_head", dat[0], 10'h012);
        for (int i = 0; i < DEPTH - 2; i++) do_read();

        // reset in the middle of a frame with words queued
        check("t6_queued", cnt[0], 2);
        partial(8'h33, 5);
        @(negedge clk) reset_n = 1'b0;
        @(posedge clk);
        #2;
        reset_values("rst_mid");
        @(negedge clk) reset_n = 1'b1;
        m_reset();
        repeat (5) @(negedge clk);
        settled = 1;
        frame(8'h1C, 0, 0, 0);
        check("t6_word", dat[0], 10'h01C);
        check("t6_count", cnt[0], 1);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: frame(8'($urandom_range(0, 255)), 0, 0, 0);
                4: frame(8'hE0, 0, 0, 0);
                5: frame(8'hF0, 0, 0, 0);
                6: frame(8'($urandom_range(0, 255)), 1, 0, 0);
                7: frame(8'($urandom_range(0, 255)), 0, 1, 0);
                default: do_read();
            endcase
        end
        repeat (4) @(negedge clk);
        settled = 0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
